// File: rtl/swipt_bridge_drive.sv
// Dead-time protected full-bridge drive for the SWIPT output pins with heartbeat watchdog,
// shadowed period-boundary config updates and latched fault. Macro SWIPT_SOFTSTART_EN adds the soft-start ramp.
module swipt_bridge_drive #(
    parameter int unsigned NUM_LEGS   = 2,
    parameter int unsigned PER_W      = 16,
    parameter int unsigned DT_W       = 8,
    parameter int unsigned HB_TIMEOUT = 1000000,
    parameter int unsigned HB_W       = 24,
    parameter int unsigned RAMP_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hb_in,
    input  logic                  enable,
    input  logic                  fault_clr,
    input  logic                  cfg_load,
    input  logic [PER_W-1:0]      period_in,
    input  logic [PER_W-1:0]      on_in,
    input  logic [DT_W-1:0]       dead_in,
    output logic                  cfg_err,
    output logic                  alive,
    output logic [1:0]            state_o,
    output logic                  period_tick,
    output logic [2*NUM_LEGS-1:0] swipt_out
);

    localparam int unsigned OUT_W = 2 * NUM_LEGS;
    localparam int unsigned SUM_W = PER_W + 1;
    localparam logic [HB_W-1:0]  HB_MAX   = HB_W'(HB_TIMEOUT);
    localparam logic [PER_W-1:0] RST_PER  = PER_W'(2500);
    localparam logic [DT_W-1:0]  RST_DEAD = DT_W'(10);
    localparam logic [SUM_W-1:0] STEP     = SUM_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state, state_next;
    logic              hb_prev;
    logic [HB_W-1:0]   hb_cnt;
    logic [PER_W-1:0]  sh_period, sh_on, act_period, act_on;
    logic [DT_W-1:0]   sh_dead, act_dead;
    logic [PER_W-1:0]  ramp, cnt;

    logic [PER_W-1:0]  half_in, half_c, pos, on_eff;
    logic              cfg_ok_c, active_c, wrap_c, in_h1, win;
    logic [PER_W-1:0]  act_period_next, act_on_next, ramp_next, cnt_next;
    logic [DT_W-1:0]   act_dead_next;
    logic [SUM_W-1:0]  ramp_sum;
    logic              tick_next;
    logic [OUT_W-1:0]  drive_next;

    assign state_o = state;

    // Config acceptance: dead + on must fit inside half a period.
    always_comb begin
        half_in  = period_in >> 1;
        cfg_ok_c = (period_in >= PER_W'(4)) &&
                   (({1'b0, on_in} + SUM_W'(dead_in)) <= {1'b0, half_in});
    end

    // Watchdog: any hb edge revives; silence for HB_TIMEOUT cycles declares loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_prev <= 1'b0;
            hb_cnt  <= '0;
            alive   <= 1'b0;
        end else begin
            hb_prev <= hb_in;
            if (hb_in ^ hb_prev) begin
                hb_cnt <= '0;
                alive  <= 1'b1;
            end else if (hb_cnt != HB_MAX) begin
                hb_cnt <= hb_cnt + HB_W'(1);
                if (hb_cnt + HB_W'(1) == HB_MAX) alive <= 1'b0;
            end else begin
                alive <= 1'b0;
            end
        end
    end

    // Shadow config and reject pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_period <= RST_PER;
            sh_on     <= '0;
            sh_dead   <= RST_DEAD;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !cfg_ok_c;
            if (cfg_load && cfg_ok_c) begin
                sh_period <= period_in;
                sh_on     <= on_in;
                sh_dead   <= dead_in;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_OFF: begin
                if (enable && alive) begin
`ifdef SWIPT_SOFTSTART_EN
                    state_next = ST_START;
`else
                    state_next = ST_RUN;
`endif
                end
            end
            ST_START: begin
                if (!alive)                          state_next = ST_FAULT;
                else if (!enable)                    state_next = ST_OFF;
                else if (wrap_c && (ramp >= act_on)) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!alive)       state_next = ST_FAULT;
                else if (!enable) state_next = ST_OFF;
            end
            ST_FAULT: begin
                if (fault_clr && !enable) state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    // Period position, drive window and next-cycle datapath values.
    always_comb begin
        active_c = (state == ST_START) || (state == ST_RUN);
        wrap_c   = active_c && (cnt >= act_period - PER_W'(1));
        half_c   = act_period >> 1;
        in_h1    = cnt >= half_c;
        pos      = in_h1 ? (cnt - half_c) : cnt;
        on_eff   = ((state == ST_START) && (ramp < act_on)) ? ramp : act_on;
        win      = ({1'b0, pos} >= SUM_W'(act_dead)) &&
                   ({1'b0, pos} < (SUM_W'(act_dead) + {1'b0, on_eff}));

        act_period_next = act_period;
        act_on_next     = act_on;
        act_dead_next   = act_dead;
        if ((state == ST_OFF) || wrap_c) begin
            act_period_next = sh_period;
            act_on_next     = sh_on;
            act_dead_next   = sh_dead;
        end

        cnt_next = '0;
        if (active_c && ((state_next == ST_START) || (state_next == ST_RUN)) && !wrap_c)
            cnt_next = cnt + PER_W'(1);

        ramp_sum  = {1'b0, ramp} + STEP;
        ramp_next = ramp;
        if (state != ST_START)
            ramp_next = '0;
        else if (wrap_c)
            ramp_next = (ramp_sum >= {1'b0, act_on_next}) ? act_on_next : PER_W'(ramp_sum);

        tick_next = ((state_next == ST_START) || (state_next == ST_RUN)) &&
                    (cnt_next == act_period_next - PER_W'(1));

        // Even legs lead with the high side in half 0, odd legs with the low side.
        drive_next = '0;
        if (active_c && ((state_next == ST_START) || (state_next == ST_RUN)) && win) begin
            for (int k = 0; k < NUM_LEGS; k++) begin
                if ((k % 2 == 0) != in_h1) drive_next[2*k]   = 1'b1;
                else                       drive_next[2*k+1] = 1'b1;
            end
        end
    end

    // State, counters, active config and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_OFF;
            act_period  <= RST_PER;
            act_on      <= '0;
            act_dead    <= RST_DEAD;
            ramp        <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
            swipt_out   <= '0;
        end else begin
            state       <= state_next;
            act_period  <= act_period_next;
            act_on      <= act_on_next;
            act_dead    <= act_dead_next;
            ramp        <= ramp_next;
            cnt         <= cnt_next;
            period_tick <= tick_next;
            swipt_out   <= drive_next;
        end
    end

endmodule

// File: tb/tb_swipt_bridge_drive.sv
// Directed scoreboard bench for swipt_bridge_drive (HB_TIMEOUT=50, RAMP_STEP=10).
module tb_swipt_bridge_drive;

    logic        clk, rst, hb_in, enable, fault_clr, cfg_load;
    logic [15:0] period_in, on_in;
    logic [7:0]  dead_in;
    logic        cfg_err, alive, period_tick;
    logic [1:0]  state_o;
    logic [3:0]  swipt_out;

    int unsigned cyc;
    bit          hb_run;
    int          n_cmp, n_err, n;
    logic [3:0]  exp_q[$];

`ifdef SWIPT_SOFTSTART_EN
    localparam logic [1:0] ST_ENTRY = 2'd1;
`else
    localparam logic [1:0] ST_ENTRY = 2'd2;
`endif

    swipt_bridge_drive #(
        .NUM_LEGS(2), .PER_W(16), .DT_W(8),
        .HB_TIMEOUT(50), .HB_W(24), .RAMP_STEP(10)
    ) dut (
        .clk(clk), .rst(rst), .hb_in(hb_in), .enable(enable),
        .fault_clr(fault_clr), .cfg_load(cfg_load),
        .period_in(period_in), .on_in(on_in), .dead_in(dead_in),
        .cfg_err(cfg_err), .alive(alive), .state_o(state_o),
        .period_tick(period_tick), .swipt_out(swipt_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (hb_run && (cyc % 20 == 0)) hb_in = ~hb_in;
    endtask

    task automatic load(input int per, input int on, input int dead);
        period_in = 16'(per);
        on_in     = 16'(on);
        dead_in   = 8'(dead);
        cfg_load  = 1'b1;
        step();
        cfg_load  = 1'b0;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (period_tick !== 1'b1 && cycles < 5000);
        chk("wait_tick", 32'(period_tick), 32'd1);
    endtask

    // Starts on a period_tick cycle; output lags cnt by one, so the first sample belongs to the old period.
    task automatic check_period(input string tag, input int per,
                                input int lo0, input int hi0, input int lo1, input int hi1);
        logic [3:0] e;
        int         c;
        for (int j = 0; j < per; j++) begin
            c = (j == 0) ? per - 1 : j - 1;
            e = 4'b0000;
            if (c >= lo0 && c <= hi0)      e = 4'b1001;
            else if (c >= lo1 && c <= hi1) e = 4'b0110;
            exp_q.push_back(e);
        end
        for (int j = 0; j < per; j++) begin
            step();
            e = exp_q.pop_front();
            chk(tag, 32'(swipt_out), 32'(e));
            chk("shoot_through", 32'((swipt_out[0] & swipt_out[1]) | (swipt_out[2] & swipt_out[3])), 32'd0);
        end
        chk({tag, "_tick"}, 32'(period_tick), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; hb_run = 1'b0;
        rst = 1'b1; hb_in = 1'b0; enable = 1'b0; fault_clr = 1'b0; cfg_load = 1'b0;
        period_in = '0; on_in = '0; dead_in = '0;

        step(); step();
        chk("rst_out", 32'(swipt_out), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_alive", 32'(alive), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;

        hb_run = 1'b1;
        n = 0;
        do begin step(); n++; end while (alive !== 1'b1 && n < 100);
        chk("alive_up", 32'(alive), 32'd1);

        load(100, 30, 5);
        chk("load_ok", 32'(cfg_err), 32'd0);
        enable = 1'b1;
        step();
        chk("enter", 32'(state_o), 32'(ST_ENTRY));
        wait_tick(n);
        chk("first_period_len", 32'(n), 32'd99);
`ifdef SWIPT_SOFTSTART_EN
        chk("ramp0_out", 32'(swipt_out), 32'd0);
        check_period("ramp10", 100, 5, 14, 55, 64);
        check_period("ramp20", 100, 5, 24, 55, 74);
        check_period("ramp30", 100, 5, 34, 55, 84);
        step();
        chk("ramp_done", 32'(state_o), 32'd2);
        wait_tick(n);
`endif
        check_period("run100", 100, 5, 34, 55, 84);

        // Rejected config: 48 + 5 exceeds half of 100.
        repeat (10) step();
        load(100, 48, 5);
        chk("reject_pulse", 32'(cfg_err), 32'd1);
        step();
        chk("reject_once", 32'(cfg_err), 32'd0);
        wait_tick(n);
        check_period("after_reject", 100, 5, 34, 55, 84);

        // Mid-period load lets the running period finish at its old length.
        repeat (10) step();
        load(200, 30, 5);
        wait_tick(n);
        chk("old_period_kept", 32'(n), 32'd89);
        check_period("run200", 200, 5, 34, 105, 134);

        // Load on the wrap cycle: the old shadow is taken, the new one waits a period.
        load(101, 40, 5);
        wait_tick(n);
        chk("wrap_load_len", 32'(n), 32'd199);
        check_period("odd101", 101, 5, 44, 55, 94);

        n = 0;
        do begin step(); n++; end while (swipt_out === 4'b0000 && n < 300);
        chk("drop_in_window", 32'(|swipt_out), 32'd1);
        enable = 1'b0;
        step();
        chk("drop_out", 32'(swipt_out), 32'd0);
        chk("drop_state", 32'(state_o), 32'd0);
        enable = 1'b1;
        step();
        chk("reenter", 32'(state_o), 32'(ST_ENTRY));

        hb_run = 1'b0;
        step();
        hb_in = ~hb_in;
        step();
        chk("wd_last_edge", 32'(alive), 32'd1);
        n = 0;
        do begin step(); n++; end while (alive !== 1'b0 && n < 200);
        chk("wd_cycles", 32'(n), 32'd50);
        step();
        chk("fault_state", 32'(state_o), 32'd3);
        chk("fault_out", 32'(swipt_out), 32'd0);

        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        step();
        chk("clr_ignored", 32'(state_o), 32'd3);
        enable = 1'b0;
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("clr_off", 32'(state_o), 32'd0);

        hb_run = 1'b1;
        enable = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_o === 2'd0 && n < 200);
        chk("restart", 32'(state_o), 32'(ST_ENTRY));
        n = 0;
        do begin step(); n++; end while (swipt_out[0] !== 1'b1 && n < 600);
        chk("hs_pulse", 32'(swipt_out[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_out", 32'(swipt_out), 32'd0);
        chk("async_state", 32'(state_o), 32'd0);
        chk("async_alive", 32'(alive), 32'd0);
        chk("async_tick", 32'(period_tick), 32'd0);
        step();
        rst = 1'b0;
        wait_tick(n);
        wait_tick(n);
        chk("rst_period_2500", 32'(n), 32'd2500);
        chk("rst_on_zero", 32'(swipt_out), 32'd0);
        chk("rst_run", 32'(state_o), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
